// File: rtl/dm_port_arbiter.sv
// rtl/dm_port_arbiter.sv - two-requester arbiter for the single data memory port (CPU priority, DMA bursts)
module dm_port_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MAX_WAIT  = 4,
    parameter int BURST_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_en,
    input  logic              cpu_rw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_rw,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    input  logic              dma_last,
    output logic              dma_gnt,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_rvalid,
    output logic              mem_en,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              owner_dma
);

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam int BW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
    localparam logic [WW-1:0] WAIT_SAT  = WW'(MAX_WAIT);
    localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_MAX - 1);

    typedef enum logic {
        S_CPU = 1'b0,
        S_DMA = 1'b1
    } state_t;

    state_t        state, state_n;
    logic [WW-1:0] wait_cnt, wait_n;
    logic [BW-1:0] beat_cnt, beat_n;
    logic          beat;

    // Grant decision: CPU wins unless the DMA has starved or already owns a burst;
    // everything is held off while reset is asserted.
    always_comb begin
        dma_gnt   = 1'b0;
        cpu_stall = 1'b0;
        if (reset) begin
            if (state == S_DMA) begin
                dma_gnt   = dma_req;
                cpu_stall = cpu_en;
            end else begin
                dma_gnt   = dma_req && (!cpu_en || wait_cnt == WAIT_SAT);
                cpu_stall = cpu_en && dma_gnt;
            end
        end
    end

    // Memory port mux; CPU values are driven when idle so the bus never floats to X.
    always_comb begin
        mem_en    = reset && cpu_en && !cpu_stall;
        mem_rw    = cpu_rw;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        if (dma_gnt) begin
            mem_en    = 1'b1;
            mem_rw    = dma_rw;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end
    end

    assign beat      = dma_req && dma_gnt;
    assign cpu_rdata = mem_rdata;
    assign dma_rdata = mem_rdata;
    assign owner_dma = (state == S_DMA);

    // Next-state: burst tracking and the saturating starvation counter.
    always_comb begin
        state_n = state;
        beat_n  = beat_cnt;
        wait_n  = wait_cnt;

        if (!dma_req) begin
            wait_n = '0;
        end else if (beat) begin
            wait_n = '0;
        end else if (wait_cnt != WAIT_SAT) begin
            wait_n = wait_cnt + WW'(1);
        end

        if (state == S_CPU) begin
            if (beat && !dma_last && BURST_MAX > 1) begin
                state_n = S_DMA;
                beat_n  = BW'(1);
            end
        end else begin
            if (!dma_req) begin
                state_n = S_CPU;
                beat_n  = '0;
            end else if (beat && (dma_last || beat_cnt == BEAT_LAST)) begin
                state_n = S_CPU;
                beat_n  = '0;
            end else if (beat) begin
                beat_n  = beat_cnt + BW'(1);
            end
        end
    end

    // State registers; an asynchronous reset abandons any burst in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_CPU;
            wait_cnt   <= '0;
            beat_cnt   <= '0;
            dma_rvalid <= 1'b0;
        end else begin
            state      <= state_n;
            wait_cnt   <= wait_n;
            beat_cnt   <= beat_n;
            dma_rvalid <= dma_gnt && !dma_rw;
        end
    end

endmodule
